// File: rtl/door_input_debounce.sv
// Synchronises and debounces the four raw door inputs, with clean-level edge pulses and a sticky limit-switch fault.
// Latency: a stable raw change reaches clean_out/rise/fall after DEBOUNCE_CYCLES+2 edges; no backpressure, ena=0 freezes state.
module door_input_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] raw_in,
  input  logic       clr_fault,
  output logic [3:0] clean_out,
  output logic [3:0] rise,
  output logic [3:0] fall,
  output logic       fault_lim
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [CNT_W-1:0] cnt [4];

  // The synchroniser free-runs so the input is never stale when ena returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 4'b0;
      sync2 <= 4'b0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      clean_out <= 4'b0;
      rise      <= 4'b0;
      fall      <= 4'b0;
    end else begin
      rise <= 4'b0;
      fall <= 4'b0;
      if (ena) begin
        for (int i = 0; i < 4; i++) begin
          if (sync2[i] == clean_out[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == CNT_TERM) begin
            clean_out[i] <= sync2[i];
            cnt[i]       <= '0;
            rise[i]      <= sync2[i];
            fall[i]      <= ~sync2[i];
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Set has priority over the clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_lim <= 1'b0;
    end else if (ena) begin
      if (clean_out[2] && clean_out[3]) fault_lim <= 1'b1;
      else if (clr_fault)               fault_lim <= 1'b0;
    end
  end

endmodule

// File: tb/tb_door_input_debounce.sv
// Scoreboarded bench: a run-length reference model predicts outputs per cycle, a monitor compares them.
module tb_door_input_debounce;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [3:0] raw_in = 4'b0;
  logic       clr_fault = 1'b0;
  logic [3:0] clean_out, rise, fall;
  logic       fault_lim;

  door_input_debounce #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .raw_in(raw_in),
    .clr_fault(clr_fault), .clean_out(clean_out), .rise(rise),
    .fall(fall), .fault_lim(fault_lim)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [12:0] exp_q [$];
  bit done = 0;

  // Reference model: sync is a two-sample delay of raw_in; clean flips once
  // N consecutive enabled samples disagree with it.
  logic [3:0] m_s1, m_s2, m_clean, m_rise, m_fall;
  logic       m_fault;
  int         m_run [4];

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_clean = 0; m_rise = 0; m_fall = 0; m_fault = 0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic e, input logic c);
    logic [3:0] nc;
    nc = m_clean;
    m_rise = 0;
    m_fall = 0;
    if (e) begin
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_clean[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == N) begin
            nc[i] = m_s2[i];
            m_run[i] = 0;
            if (m_s2[i]) m_rise[i] = 1'b1;
            else         m_fall[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_fault = (m_clean[2] & m_clean[3]) | (m_fault & ~c);
    end
    m_clean = nc;
    m_s2 = m_s1;
    m_s1 = r;
  endtask

  task automatic step(input logic [3:0] r, input logic e, input logic c, input logic rn);
    @(negedge clk);
    raw_in = r; ena = e; clr_fault = c; rst_n = rn;
    if (!rn) model_reset();
    else     model_step(r, e, c);
    exp_q.push_back({m_clean, m_rise, m_fall, m_fault});
  endtask

  task automatic hold(input logic [3:0] r, input int n);
    for (int k = 0; k < n; k++) step(r, 1'b1, 1'b0, 1'b1);
  endtask

  // Monitor: every edge the DUT presents a new output vector.
  initial begin
    logic [12:0] exp_v, act_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {clean_out, rise, fall, fault_lim};
        tests++;
        if (act_v !== exp_v) begin
          fails++;
          $display("FAIL outputs t=%0t clean/rise/fall/fault got %b/%b/%b/%b want %b/%b/%b/%b",
                   $time, act_v[12:9], act_v[8:5], act_v[4:1], act_v[0],
                   exp_v[12:9], exp_v[8:5], exp_v[4:1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    model_reset();
    for (int k = 0; k < 3; k++) step(4'b0000, 1'b1, 1'b0, 1'b0);
    hold(4'b0001, 12);
    // short glitch on stop input
    hold(4'b0011, 3);
    hold(4'b0001, 10);
    hold(4'b0000, 10);
    // enable dropped mid-count
    for (int k = 0; k < 20; k++) step(4'b0001, !(k >= 4 && k < 9), 1'b0, 1'b1);
    // both limit switches, clear while held, then clear after release
    hold(4'b1101, 10);
    step(4'b1101, 1'b1, 1'b1, 1'b1);
    hold(4'b1101, 3);
    hold(4'b0101, 8);
    step(4'b0101, 1'b1, 1'b1, 1'b1);
    hold(4'b0101, 3);
    // reset in the middle of a debounce
    hold(4'b0000, 10);
    hold(4'b0001, 4);
    step(4'b0001, 1'b1, 1'b0, 1'b0);
    hold(4'b0001, 10);
    // simultaneous multi-channel flip
    hold(4'b0000, 10);
    hold(4'b1011, 10);
    // randomized phase
    r = 4'b0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(7) == 0) r[i] = ~r[i];
      step(r, $urandom_range(9) != 0, $urandom_range(9) == 0, $urandom_range(299) != 0);
    end
    hold(r, 3);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain leftover expectations got %0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
